// File: rtl/dmem_req_demux_pkg.sv
// Shared definitions for the data-memory request demux and its users.
package dmem_req_demux_pkg;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    // Default MMIO window: the top 64 KiB of the address space.
    localparam logic [REQ_ADDR_W-1:0] DEF_MMIO_BASE = 32'hFFFF_0000;
    localparam logic [REQ_ADDR_W-1:0] DEF_MMIO_MASK = 32'hFFFF_0000;

    localparam logic PORT_DMEM = 1'b0;
    localparam logic PORT_MMIO = 1'b1;

    // Request as issued by the core's load/store unit.
    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic                  we;
    } dmem_req_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } demux_state_t;

endpackage

// File: rtl/dmem_req_demux_if.sv
// Request bus around the demux: core-side request channel plus the two
// target-side channels that share one payload.
interface dmem_req_demux_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic              in_we;

    logic              out0_valid;
    logic              out0_ready;
    logic              out1_valid;
    logic              out1_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_wdata;
    logic              out_we;

    // Environment side: issues requests and plays both targets.
    modport master (
        output in_valid, in_addr, in_wdata, in_we, out0_ready, out1_ready,
        input  in_ready, out0_valid, out1_valid, out_addr, out_wdata, out_we
    );

    // Demux side.
    modport slave (
        input  in_valid, in_addr, in_wdata, in_we, out0_ready, out1_ready,
        output in_ready, out0_valid, out1_valid, out_addr, out_wdata, out_we
    );
endinterface

// File: rtl/dmem_req_demux_addr_decode.sv
// MMIO window hit detection: masked address compare against the window base.
module dmem_req_demux_addr_decode #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [ADDR_W-1:0] MMIO_MASK = 32'hFFFF_0000
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit
);

    // Purely combinational; only sampled by the parent on accept.
    assign o_hit = ((i_addr & MMIO_MASK) == MMIO_BASE);

endmodule

// File: rtl/dmem_req_demux.sv
// One-entry registered 1:2 demux for data-memory requests. Port 0 goes to
// data memory, port 1 to the MMIO window. Counts handshakes per port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | no request held; in_ready=1, both out valids low
// ST_FULL  | request held for port r_dst; payload frozen until drained
module dmem_req_demux
    import dmem_req_demux_pkg::*;
#(
    parameter int                DATA_W    = REQ_DATA_W,
    parameter int                ADDR_W    = REQ_ADDR_W,
    parameter logic [ADDR_W-1:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter logic [ADDR_W-1:0] MMIO_MASK = DEF_MMIO_MASK,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    dmem_req_demux_if.slave   bus,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    demux_state_t      r_state;
    logic              r_dst;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic w_hit;
    logic w_full;
    logic w_out0_valid;
    logic w_out1_valid;
    logic w_drain0;
    logic w_drain1;
    logic w_drain;
    logic w_in_ready;
    logic w_accept;

    dmem_req_demux_addr_decode #(
        .ADDR_W    (ADDR_W),
        .MMIO_BASE (MMIO_BASE),
        .MMIO_MASK (MMIO_MASK)
    ) u_addr_decode (
        .i_addr (bus.in_addr),
        .o_hit  (w_hit)
    );

    // Handshake decode; a ready on the port that is not addressed is ignored.
    always_comb begin
        w_full       = (r_state == ST_FULL);
        w_out0_valid = w_full & (r_dst == PORT_DMEM);
        w_out1_valid = w_full & (r_dst == PORT_MMIO);
        w_drain0     = w_out0_valid & bus.out0_ready;
        w_drain1     = w_out1_valid & bus.out1_ready;
        w_drain      = w_drain0 | w_drain1;
        // Drain frees the slot in the same cycle, giving one request per cycle.
        w_in_ready   = ~w_full | w_drain;
        w_accept     = bus.in_valid & w_in_ready;
    end

    // Slot FSM, payload capture and per-port handshake counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_dst   <= PORT_DMEM;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_drain && !w_accept) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase

            // Payload only moves on accept, so a stalled request stays put.
            if (w_accept) begin
                r_dst   <= w_hit ? PORT_MMIO : PORT_DMEM;
                r_addr  <= bus.in_addr;
                r_wdata <= bus.in_wdata;
                r_we    <= bus.in_we;
            end

            if (w_drain0) begin
                r_cnt0 <= r_cnt0 + CNT_ONE;
            end
            if (w_drain1) begin
                r_cnt1 <= r_cnt1 + CNT_ONE;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out0_valid = w_out0_valid;
    assign bus.out1_valid = w_out1_valid;
    assign bus.out_addr   = r_addr;
    assign bus.out_wdata  = r_wdata;
    assign bus.out_we     = r_we;
    assign cnt0           = r_cnt0;
    assign cnt1           = r_cnt1;

endmodule

// File: tb/tb_dmem_req_demux.sv
// Bench for dmem_req_demux: vector table for routing/stall/stream behaviour,
// plus hand-written reset-while-full and 4-bit counter wrap sequences.
module tb_dmem_req_demux;
    import dmem_req_demux_pkg::*;

    logic clk;
    logic rst;
    logic [15:0] a_cnt0, a_cnt1;
    logic [3:0]  b_cnt0, b_cnt1;

    int checks = 0;
    int errors = 0;

    dmem_req_demux_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    dmem_req_demux_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

    dmem_req_demux #(.CNT_W(16)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifa.slave),
        .cnt0 (a_cnt0),
        .cnt1 (a_cnt1)
    );

    dmem_req_demux #(.CNT_W(4)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifb.slave),
        .cnt0 (b_cnt0),
        .cnt1 (b_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        dmem_req_t   req;
        logic        r0;
        logic        r1;
        logic        x_rdy;
        logic        x_v0;
        logic        x_v1;
        dmem_req_t   x_req;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic dmem_req_t mkreq(input logic [31:0] a, input logic [31:0] d, input logic w);
        dmem_req_t r;
        r.addr  = a;
        r.wdata = d;
        r.we    = w;
        return r;
    endfunction

    function automatic vec_t mkvec(input logic vld, input dmem_req_t req, input logic r0,
                                   input logic r1, input logic x_rdy, input logic x_v0,
                                   input logic x_v1, input dmem_req_t x_req);
        vec_t v;
        v.vld = vld; v.req = req; v.r0 = r0; v.r1 = r1;
        v.x_rdy = x_rdy; v.x_v0 = x_v0; v.x_v1 = x_v1; v.x_req = x_req;
        return v;
    endfunction

    function automatic dmem_req_t stream_req(input int k);
        logic [31:0] a;
        logic [31:0] kk;
        kk = 32'(k);
        if (k % 2 == 1) a = 32'hFFFF_0000 + (kk << 2);
        else            a = 32'h0000_0200 + (kk << 2);
        return mkreq(a, 32'hA000_0000 + kk, (k % 3) == 0);
    endfunction

    // Port valids must never both be high.
    always @(negedge clk) begin
        checks++;
        if (ifa.out0_valid && ifa.out1_valid) begin
            errors++;
            $display("FAIL both_valids: got 11 want not 11");
        end
    end

    initial begin
        dmem_req_t z;
        dmem_req_t st;
        dmem_req_t mm;
        dmem_req_t nx;
        z  = mkreq(32'h0, 32'h0, 1'b0);
        st = mkreq(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        mm = mkreq(32'hFFFF_0004, 32'h0000_0000, 1'b0);
        nx = mkreq(32'h0000_0100, 32'h1111_1111, 1'b1);

        // Expected outputs are for the state held before each row's clock edge.
        vecs[0] = mkvec(1, st, 1, 0, 1, 0, 0, z);
        vecs[1] = mkvec(0, z,  1, 0, 1, 1, 0, st);
        vecs[2] = mkvec(0, z,  1, 0, 1, 0, 0, z);
        vecs[3] = mkvec(1, mm, 0, 0, 1, 0, 0, z);
        vecs[4] = mkvec(1, nx, 1, 0, 0, 0, 1, mm);
        vecs[5] = mkvec(1, nx, 1, 0, 0, 0, 1, mm);
        vecs[6] = mkvec(1, nx, 0, 0, 0, 0, 1, mm);
        vecs[7] = mkvec(1, nx, 0, 1, 1, 0, 1, mm);
        vecs[8] = mkvec(0, z,  0, 1, 0, 1, 0, nx);
        vecs[9] = mkvec(0, z,  1, 0, 1, 1, 0, nx);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) vecs[10] = mkvec(1, stream_req(0), 1, 1, 1, 0, 0, z);
            else vecs[10+k] = mkvec(1, stream_req(k), 1, 1, 1,
                                    (k % 2) == 1, (k % 2) == 0, stream_req(k-1));
        end
        vecs[18] = mkvec(0, z, 1, 1, 1, 0, 1, stream_req(7));
        vecs[19] = mkvec(0, z, 1, 1, 1, 0, 0, z);

        rst = 1'b1;
        ifa.in_valid = 0; ifa.in_addr = '0; ifa.in_wdata = '0; ifa.in_we = 0;
        ifa.out0_ready = 0; ifa.out1_ready = 0;
        ifb.in_valid = 0; ifb.in_addr = '0; ifb.in_wdata = '0; ifb.in_we = 0;
        ifb.out0_ready = 0; ifb.out1_ready = 0;
        cyc();
        chk("rst in_ready", 32'(ifa.in_ready), 32'd1);
        cyc();
        rst = 1'b0;
        cyc();
        chk("idle in_ready", 32'(ifa.in_ready), 32'd1);
        chk("idle out0_valid", 32'(ifa.out0_valid), 32'd0);
        chk("idle out1_valid", 32'(ifa.out1_valid), 32'd0);
        chk("idle cnt0", 32'(a_cnt0), 32'd0);
        chk("idle cnt1", 32'(a_cnt1), 32'd0);
        chk("idle out_addr", ifa.out_addr, 32'd0);

        for (int i = 0; i < NV; i++) begin
            ifa.in_valid   = vecs[i].vld;
            ifa.in_addr    = vecs[i].req.addr;
            ifa.in_wdata   = vecs[i].req.wdata;
            ifa.in_we      = vecs[i].req.we;
            ifa.out0_ready = vecs[i].r0;
            ifa.out1_ready = vecs[i].r1;
            #1;
            chk($sformatf("row%0d in_ready", i), 32'(ifa.in_ready), 32'(vecs[i].x_rdy));
            chk($sformatf("row%0d out0_valid", i), 32'(ifa.out0_valid), 32'(vecs[i].x_v0));
            chk($sformatf("row%0d out1_valid", i), 32'(ifa.out1_valid), 32'(vecs[i].x_v1));
            if (vecs[i].x_v0 || vecs[i].x_v1) begin
                chk($sformatf("row%0d out_addr", i), ifa.out_addr, vecs[i].x_req.addr);
                chk($sformatf("row%0d out_wdata", i), ifa.out_wdata, vecs[i].x_req.wdata);
                chk($sformatf("row%0d out_we", i), 32'(ifa.out_we), 32'(vecs[i].x_req.we));
            end
            if (i == 2) chk("store cnt0", 32'(a_cnt0), 32'd1);
            if (i == 8) chk("mmio cnt1", 32'(a_cnt1), 32'd1);
            cyc();
        end
        // 2 earlier port-0 and 1 port-1 handshakes, then 4 + 4 from the stream.
        chk("stream cnt0", 32'(a_cnt0), 32'd6);
        chk("stream cnt1", 32'(a_cnt1), 32'd5);

        // Reset while a port-1 request is stalled: it must be discarded.
        ifa.in_valid = 1; ifa.in_addr = 32'hFFFF_0008; ifa.in_wdata = 32'h5555_AAAA;
        ifa.in_we = 1; ifa.out0_ready = 1; ifa.out1_ready = 0;
        cyc();
        ifa.in_valid = 0;
        #1;
        chk("prerst out1_valid", 32'(ifa.out1_valid), 32'd1);
        chk("prerst out_addr", ifa.out_addr, 32'hFFFF_0008);
        rst = 1'b1;
        cyc();
        chk("midrst out1_valid", 32'(ifa.out1_valid), 32'd0);
        chk("midrst in_ready", 32'(ifa.in_ready), 32'd1);
        chk("midrst cnt0", 32'(a_cnt0), 32'd0);
        chk("midrst cnt1", 32'(a_cnt1), 32'd0);
        chk("midrst out_addr", ifa.out_addr, 32'd0);
        rst = 1'b0;
        ifa.out1_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("postrst%0d out1_valid", i), 32'(ifa.out1_valid), 32'd0);
            chk($sformatf("postrst%0d cnt1", i), 32'(a_cnt1), 32'd0);
        end

        // 17 port-0 handshakes on the 4-bit counter instance: wraps to 1.
        ifb.in_addr = 32'h0000_0040; ifb.in_wdata = 32'h0; ifb.in_we = 0;
        ifb.out0_ready = 1; ifb.out1_ready = 1;
        for (int i = 0; i < 17; i++) begin
            ifb.in_valid = 1;
            cyc();
            if (i == 16) chk("wrap cnt0 at 16", 32'(b_cnt0), 32'd0);
        end
        ifb.in_valid = 0;
        cyc();
        chk("wrap cnt0 at 17", 32'(b_cnt0), 32'd1);
        chk("wrap cnt1", 32'(b_cnt1), 32'd0);
        chk("wrap out0_valid", 32'(ifb.out0_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
